// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the iterative multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - start/done handshake bundle between controller and multiplier
interface mult_seq_if #(
  parameter int WIDTH = 32
);

  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] z;

  modport master (
    output start, sgn, a, b,
    input  busy, done, z
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, z
  );

endinterface

// File: rtl/cond_neg.sv
// rtl/cond_neg.sv - combinational conditional two's-complement negate
module cond_neg #(
  parameter int N = 32
) (
  input  logic         en,
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);

  assign y = en ? (~x + {{(N-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - shift-add multiplier, one partial-product bit per cycle
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_seq_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] z_fix;
  logic [WIDTH:0]     sum;

  cond_neg #(.N(WIDTH)) u_neg_a (
    .en (bus.sgn & bus.a[WIDTH-1]),
    .x  (bus.a),
    .y  (a_mag)
  );

  cond_neg #(.N(WIDTH)) u_neg_b (
    .en (bus.sgn & bus.b[WIDTH-1]),
    .x  (bus.b),
    .y  (b_mag)
  );

  cond_neg #(.N(2*WIDTH)) u_neg_z (
    .en (neg),
    .x  ({hi, lo}),
    .y  (z_fix)
  );

  // lo doubles as the multiplier shift register; product bits enter from the top.
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      hi       <= '0;
      lo       <= '0;
      neg      <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.z    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand    <= a_mag;
            lo       <= b_mag;
            hi       <= '0;
            neg      <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt      <= CW'(WIDTH);
            bus.busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          hi  <= sum[WIDTH:1];
          lo  <= {sum[0], lo[WIDTH-1:1]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          bus.z    <= z_fix;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - directed self-checking bench for mult_seq at WIDTH=32
module tb_mult_seq;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   edges;
  int   k;
  int   n;

  mult_seq_if #(.WIDTH(32)) bus ();

  mult_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [31:0] aa,
                     input logic [31:0] bb, input logic [63:0] exp);
    @(negedge clk);
    bus.sgn   = s;
    bus.a     = aa;
    bus.b     = bb;
    bus.start = 1'b1;
    @(negedge clk);
    k         = edges;
    bus.start = 1'b0;
    bus.sgn   = ~s;
    bus.a     = ~aa;
    bus.b     = 32'h1234_5678;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done();
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_lat"}, 64'(edges - k), 64'd33);
    chk({tag, "_z"}, bus.z, exp);
    chk({tag, "_busy_lo"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_hold"}, bus.z, exp);
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b0;
    checks    = 0;
    errors    = 0;
    edges     = 0;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_z", bus.z, 64'd0);
    reset = 1'b1;

    run("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run("u_zero", 1'b0, 32'h0, 32'hFFFF_FFFF, 64'h0);
    run("s_m1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
    run("s_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run("s_45m104", 1'b1, 32'd45, 32'hFFFF_FF98, 64'hFFFF_FFFF_FFFF_EDB8);
    run("u_min2", 1'b0, 32'h8000_0000, 32'd2, 64'h1_0000_0000);
    run("s_min1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    run("s_maxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    run("u_shift", 1'b0, 32'h1234_5678, 32'h10, 64'h1_2345_6780);
    run("s_7m3", 1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);

    // Reset mid-CALC: outputs must clear without waiting for a clock edge.
    @(negedge clk);
    bus.sgn   = 1'b0;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_z", bus.z, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_done();
    chk("mid_rst_no_done", 64'(n), 64'd100);
    run("after_rst", 1'b0, 32'd3, 32'd5, 64'd15);

    // Back-to-back: second start raised during the first done cycle.
    @(negedge clk);
    bus.sgn   = 1'b0;
    bus.a     = 32'd71;
    bus.b     = 32'd14;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    chk("b2b_z1", bus.z, 64'd994);
    k         = edges;
    bus.a     = 32'd45;
    bus.b     = 32'd104;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy2", 64'(bus.busy), 64'd1);
    repeat (5) @(negedge clk);
    bus.a     = 32'd1000;
    bus.b     = 32'd1000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    chk("b2b_lat", 64'(edges - k), 64'd34);
    chk("b2b_z2", bus.z, 64'd4680);
    @(negedge clk);
    wait_done();
    chk("b2b_ignored", 64'(n), 64'd100);
    chk("b2b_idle", 64'(bus.busy), 64'd0);
    chk("b2b_keep", bus.z, 64'd4680);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised iterative multiplier with signed/unsigned mode and a start/done handshake, replacing the fixed 32×32 unsigned multiplier in the CPU datapath. Computes a full 2·WIDTH-bit product of two WIDTH-bit operands, one partial-product bit per cycle. It sits beside the ALU and serves MULT/MULTU; the controller stalls on `busy` and writes HI/LO from `z` when `done` pulses.

## Interface
- `WIDTH`, 32, operand width in bits; legal range 2..64
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (asserts immediately when 0, releases synchronously to `clk`)
- `start`  in  1  request; sampled only while idle
- `sgn`  in  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with `start`
- `a`  in  WIDTH  multiplicand; sampled with `start`
- `b`  in  WIDTH  multiplier; sampled with `start`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse; `z` is valid from this cycle onward
- `z`  out  2·WIDTH  product; holds its value until the next `done`

## Operation
- States: IDLE, CALC, FIX.
- IDLE: if `start`=1 at a clock edge, latch |a| and |b| (magnitudes when `sgn`=1, raw bits when `sgn`=0) and `neg` = `sgn` & (a[MSB] ^ b[MSB]). Clear the accumulator, load the counter with WIDTH, and go to CALC. `start`=0: stay.
- CALC: each cycle, if multiplier LSB = 1, add the multiplicand to the upper WIDTH+1 bits of the accumulator. Shift {carry, acc, multiplier} right by 1 and decrement the counter. When the counter reaches 1, go to FIX on that edge (exactly WIDTH CALC cycles).
- FIX: `z` ← `neg` ? −acc : acc, computed modulo 2^(2·WIDTH). `done` ← 1. Go to IDLE.
- `a`, `b`, `sgn` may change freely after acceptance; the result uses the latched values.
- `start` while `busy`=1 is ignored and not queued.
- Most-negative operands: the magnitude of 100…0 is 2^(WIDTH−1), held unsigned in WIDTH bits. No overflow is possible, and the product always fits in 2·WIDTH bits.
- Reset (including mid-operation): state IDLE, `busy`=0, `done`=0, `z`=0, counter/accumulator cleared. The in-flight operation is discarded and produces no `done`.

## Timing
- `start` accepted at edge k. Then:
  - `busy`=1 after edge k.
  - CALC occupies edges k+1..k+WIDTH.
  - FIX result registers at edge k+WIDTH+1; `done`=1 and `busy`=0 for the cycle after it.
  - Latency: WIDTH+1 edges from acceptance to `z` valid (33 for WIDTH=32).
- `done` cycle is IDLE: a `start` during the `done` cycle is accepted, giving back-to-back throughput of one result per WIDTH+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `mult_pkg`: state enum (IDLE/CALC/FIX) and a `cnt_w(WIDTH)` function returning $clog2(WIDTH+1).
- Sub-module `cond_neg #(N)`: combinational conditional two's-complement negate (`y = en ? −x : x`). Three instances:
  - N=WIDTH for operand a;
  - N=WIDTH for operand b;
  - N=2·WIDTH for the result.
- Single always_ff for the FSM and datapath; the adder is WIDTH+1 bits wide.

## Test plan
- WIDTH=32, reset low mid-CALC (cycle 10 after start) → `busy`/`done`/`z` go to 0 immediately. No `done` follows after release; the next start runs normally.
- WIDTH=32, `sgn`=0:
  - a=0xFFFFFFFF, b=0xFFFFFFFF → z=0xFFFFFFFE00000001, `done` exactly 33 edges after the start edge.
  - a=0, b=0xFFFFFFFF → z=0.
- WIDTH=32, `sgn`=1:
  - a=0xFFFFFFFF, b=0xFFFFFFFF → z=1.
  - a=0x80000000, b=0x80000000 → z=0x4000000000000000.
  - a=45, b=−104 → z=0xFFFFFFFFFFFFEDB8 (−4680).
- Back-to-back: start a=71, b=14 (`sgn`=0), then raise `start` with a=45, b=104 in the `done` cycle → z=994, then z=4680 exactly 34 edges later. A `start` pulsed mid-CALC is ignored.
- WIDTH=8 and WIDTH=17, 10k random operands in both modes vs. a reference `*` model → all match; `done` latency = WIDTH+1 every time.
